// File: rtl/uart_tx_param_if.sv
// Handshake and line bundle between a word source and the uart_tx_param serialiser.
interface uart_tx_param_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  uart_txd;
   logic                  tx_busy;
   logic                  tx_done;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  uart_txd,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output uart_txd,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_WIDTH data bits, optional parity,
// 1 or 2 stop bits. One word per valid/ready handshake, all outputs registered.
module uart_tx_param #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int MSB_FIRST   = 0
) (
   input logic              sys_clk,
   input logic              sys_rst_n,
   uart_tx_param_if.slave   bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] BAUD_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BAUD_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_WIDTH - 1);
   localparam logic             STOP_LAST     = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                 state_r;
   logic [DATA_WIDTH-1:0]  shift_r;
   logic                   parity_r;
   logic [CNT_W-1:0]       baud_cnt_r;
   logic [IDX_W-1:0]       bit_idx_r;
   logic                   stop_idx_r;
   logic                   txd_r;
   logic                   ready_r;
   logic                   busy_r;
   logic                   done_r;
   logic                   bit_end_s;
   logic                   frame_end_s;

   function automatic logic [DATA_WIDTH-1:0] reverse_bits(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      r = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < DATA_WIDTH; i++) begin
         r[i] = d[DATA_WIDTH-1-i];
      end
      return r;
   endfunction

   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
      if (PARITY_MODE == 1) begin
         return ~^d;
      end else begin
         return ^d;
      end
   endfunction

   // Bit-period end and frame-end strobes from the baud counter.
   always_comb begin
      bit_end_s   = (baud_cnt_r == BAUD_LAST);
      // IDLE is entered one cycle early: that first IDLE cycle still drives the
      // line high, completing the last stop bit while a new word can be accepted.
      frame_end_s = (stop_idx_r == STOP_LAST) && (baud_cnt_r == BAUD_PRE_LAST);
   end

   // Frame sequencer with registered line and handshake outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r    <= IDLE;
         shift_r    <= {DATA_WIDTH{1'b0}};
         parity_r   <= 1'b0;
         baud_cnt_r <= {CNT_W{1'b0}};
         bit_idx_r  <= {IDX_W{1'b0}};
         stop_idx_r <= 1'b0;
         txd_r      <= 1'b1;
         ready_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               baud_cnt_r <= {CNT_W{1'b0}};
               stop_idx_r <= 1'b0;
               if (bus.tx_valid && ready_r) begin
                  shift_r  <= (MSB_FIRST != 0) ? reverse_bits(bus.tx_data) : bus.tx_data;
                  parity_r <= parity_bit(bus.tx_data);
                  state_r  <= START;
                  txd_r    <= 1'b0;
                  ready_r  <= 1'b0;
                  busy_r   <= 1'b1;
               end else begin
                  txd_r    <= 1'b1;
                  ready_r  <= 1'b1;
                  busy_r   <= 1'b0;
               end
            end
            START: begin
               if (bit_end_s) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  bit_idx_r  <= {IDX_W{1'b0}};
                  state_r    <= DATA;
                  txd_r      <= shift_r[0];
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  if (bit_idx_r == IDX_LAST) begin
                     if (PARITY_MODE != 0) begin
                        state_r <= PARITY;
                        txd_r   <= parity_r;
                     end else begin
                        state_r <= STOP;
                        txd_r   <= 1'b1;
                     end
                  end else begin
                     bit_idx_r <= bit_idx_r + IDX_W'(1);
                     shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                     txd_r     <= shift_r[1];
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_W'(1);
               end
            end
            PARITY: begin
               if (bit_end_s) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  stop_idx_r <= 1'b0;
                  state_r    <= STOP;
                  txd_r      <= 1'b1;
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_W'(1);
               end
            end
            STOP: begin
               txd_r <= 1'b1;
               if (frame_end_s) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  stop_idx_r <= 1'b0;
                  state_r    <= IDLE;
                  done_r     <= 1'b1;
                  ready_r    <= 1'b1;
                  busy_r     <= 1'b0;
               end else if (bit_end_s) begin
                  baud_cnt_r <= {CNT_W{1'b0}};
                  stop_idx_r <= 1'b1;
               end else begin
                  baud_cnt_r <= baud_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r    <= IDLE;
               baud_cnt_r <= {CNT_W{1'b0}};
               stop_idx_r <= 1'b0;
               txd_r      <= 1'b1;
               ready_r    <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.uart_txd = txd_r;
   assign bus.tx_ready = ready_r;
   assign bus.tx_busy  = busy_r;
   assign bus.tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: six parameter variants at 10 clocks per bit, each frame
// checked cycle by cycle against a scoreboard of expected line bits.
module tb_uart_tx_param;

   localparam int CPB = 10;

   logic sys_clk;
   logic sys_rst_n;
   int   tests;
   int   failed;

   int cfg_dw   [6] = '{8, 8, 8, 8, 8, 5};
   int cfg_par  [6] = '{0, 0, 2, 1, 2, 1};
   int cfg_stop [6] = '{1, 1, 1, 1, 2, 1};
   int cfg_msb  [6] = '{0, 1, 0, 0, 0, 0};

   logic [8:0] data_v  [6];
   logic       valid_v [6];
   logic       txd_w   [6];
   logic       ready_w [6];
   logic       busy_w  [6];
   logic       done_w  [6];

   logic exp_q [$];
   int   len_q [$];

   uart_tx_param_if #(.DATA_WIDTH(8)) if0 ();
   uart_tx_param_if #(.DATA_WIDTH(8)) if1 ();
   uart_tx_param_if #(.DATA_WIDTH(8)) if2 ();
   uart_tx_param_if #(.DATA_WIDTH(8)) if3 ();
   uart_tx_param_if #(.DATA_WIDTH(8)) if4 ();
   uart_tx_param_if #(.DATA_WIDTH(5)) if5 ();

   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                   .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(0))
      u0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if0.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                   .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(1))
      u1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if1.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                   .PARITY_MODE(2), .STOP_BITS(1), .MSB_FIRST(0))
      u2 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if2.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                   .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(0))
      u3 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if3.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                   .PARITY_MODE(2), .STOP_BITS(2), .MSB_FIRST(0))
      u4 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if4.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(5),
                   .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(0))
      u5 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if5.slave));

   assign if0.tx_data = data_v[0][7:0];
   assign if1.tx_data = data_v[1][7:0];
   assign if2.tx_data = data_v[2][7:0];
   assign if3.tx_data = data_v[3][7:0];
   assign if4.tx_data = data_v[4][7:0];
   assign if5.tx_data = data_v[5][4:0];
   assign if0.tx_valid = valid_v[0];
   assign if1.tx_valid = valid_v[1];
   assign if2.tx_valid = valid_v[2];
   assign if3.tx_valid = valid_v[3];
   assign if4.tx_valid = valid_v[4];
   assign if5.tx_valid = valid_v[5];

   assign txd_w   = '{if0.uart_txd, if1.uart_txd, if2.uart_txd, if3.uart_txd, if4.uart_txd, if5.uart_txd};
   assign ready_w = '{if0.tx_ready, if1.tx_ready, if2.tx_ready, if3.tx_ready, if4.tx_ready, if5.tx_ready};
   assign busy_w  = '{if0.tx_busy,  if1.tx_busy,  if2.tx_busy,  if3.tx_busy,  if4.tx_busy,  if5.tx_busy};
   assign done_w  = '{if0.tx_done,  if1.tx_done,  if2.tx_done,  if3.tx_done,  if4.tx_done,  if5.tx_done};

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected line bits for one frame: start, data in line order, parity, stop(s).
   task automatic push_frame(input int idx, input logic [8:0] word);
      int   n;
      int   ones;
      logic b;
      logic p;
      n    = 0;
      ones = 0;
      exp_q.push_back(1'b0);
      n++;
      for (int i = 0; i < cfg_dw[idx]; i++) begin
         b = (cfg_msb[idx] != 0) ? word[cfg_dw[idx]-1-i] : word[i];
         exp_q.push_back(b);
         if (b) ones++;
         n++;
      end
      if (cfg_par[idx] != 0) begin
         p = ((ones % 2) == 1);
         exp_q.push_back((cfg_par[idx] == 2) ? p : !p);
         n++;
      end
      for (int s = 0; s < cfg_stop[idx]; s++) begin
         exp_q.push_back(1'b1);
         n++;
      end
      len_q.push_back(n);
   endtask

   task automatic drive_word(input int idx, input logic [8:0] word, input bit hold);
      bit got;
      got = 1'b0;
      @(negedge sys_clk);
      data_v[idx]  = word;
      valid_v[idx] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (ready_w[idx] === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge sys_clk);
      end
      tests++;
      if (!got) begin
         failed++;
         $display("FAIL accept[%0d]: tx_ready=%b, required 1 within 50 cycles", idx, ready_w[idx]);
      end
      @(posedge sys_clk);
      #1;
      if (!hold) valid_v[idx] = 1'b0;
   endtask

   task automatic check_frame(input int idx, input string name);
      int   n;
      logic exp;
      logic last;
      logic bad_val;
      bit   bad;
      bit   ctl_bad;
      int   ctl_cycle;
      ctl_bad   = 1'b0;
      ctl_cycle = -1;
      tests++;
      if (len_q.size() == 0) begin
         failed++;
         $display("FAIL %s: scoreboard empty, required a queued frame", name);
         return;
      end
      n = len_q.pop_front();
      for (int b = 0; b < n; b++) begin
         exp     = exp_q.pop_front();
         bad     = 1'b0;
         bad_val = exp;
         for (int c = 0; c < CPB; c++) begin
            @(negedge sys_clk);
            last = (b == n - 1) && (c == CPB - 1);
            if (txd_w[idx] !== exp && !bad) begin
               bad     = 1'b1;
               bad_val = txd_w[idx];
            end
            if ((done_w[idx] !== last || ready_w[idx] !== last || busy_w[idx] !== !last) && !ctl_bad) begin
               ctl_bad   = 1'b1;
               ctl_cycle = b * CPB + c;
            end
         end
         tests++;
         if (bad) begin
            failed++;
            $display("FAIL %s bit %0d: line=%b, required %b for %0d cycles", name, b, bad_val, exp, CPB);
         end
      end
      if (ctl_bad) begin
         failed++;
         $display("FAIL %s flags: cycle %0d done/ready/busy=%b%b%b, required %b%b%b", name, ctl_cycle,
                  done_w[idx], ready_w[idx], busy_w[idx], 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic check_idle(input int idx, input int cycles, input string name);
      bit bad;
      bad = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge sys_clk);
         if (txd_w[idx] !== 1'b1 || done_w[idx] !== 1'b0 || ready_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0)
            bad = 1'b1;
      end
      tests++;
      if (bad) begin
         failed++;
         $display("FAIL %s idle: txd/done/ready/busy=%b%b%b%b, required 1010", name,
                  txd_w[idx], done_w[idx], ready_w[idx], busy_w[idx]);
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if ({txd_w[i], ready_w[i], busy_w[i], done_w[i]} !== 4'b1000) begin
            failed++;
            $display("FAIL reset[%0d]: txd/ready/busy/done=%b%b%b%b, required 1000", i,
                     txd_w[i], ready_w[i], busy_w[i], done_w[i]);
         end
      end
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (ready_w[i] !== 1'b1) begin
            failed++;
            $display("FAIL ready_after_reset[%0d]: tx_ready=%b, required 1", i, ready_w[i]);
         end
      end
   endtask

   task automatic test_single(input int idx, input logic [8:0] word, input string name);
      push_frame(idx, word);
      drive_word(idx, word, 1'b0);
      check_frame(idx, name);
      check_idle(idx, 5, name);
   endtask

   task automatic test_back_to_back();
      push_frame(0, 9'h055);
      push_frame(0, 9'h0A3);
      drive_word(0, 9'h055, 1'b1);
      data_v[0] = 9'h0A3;
      fork
         begin
            repeat (100) @(posedge sys_clk);
            #1;
            valid_v[0] = 1'b0;
         end
         begin
            check_frame(0, "b2b_first");
            check_frame(0, "b2b_second");
         end
      join
      check_idle(0, 30, "b2b_after");
   endtask

   task automatic test_reset_mid_frame();
      bit done_seen;
      done_seen = 1'b0;
      drive_word(0, 9'h000, 1'b0);
      repeat (45) @(negedge sys_clk);
      tests++;
      if (txd_w[0] !== 1'b0) begin
         failed++;
         $display("FAIL abort_pre: line=%b in data bit 3, required 0", txd_w[0]);
      end
      #2;
      sys_rst_n = 1'b0;
      #1;
      tests++;
      if ({txd_w[0], ready_w[0], busy_w[0]} !== 3'b100) begin
         failed++;
         $display("FAIL abort_async: txd/ready/busy=%b%b%b, required 100", txd_w[0], ready_w[0], busy_w[0]);
      end
      repeat (3) begin
         @(negedge sys_clk);
         if (done_w[0] !== 1'b0) done_seen = 1'b1;
      end
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      if (done_w[0] !== 1'b0) done_seen = 1'b1;
      tests++;
      if (done_seen) begin
         failed++;
         $display("FAIL abort_done: tx_done pulsed after abort, required 0");
      end
      tests++;
      if (ready_w[0] !== 1'b1 || txd_w[0] !== 1'b1) begin
         failed++;
         $display("FAIL abort_release: ready/txd=%b%b, required 11", ready_w[0], txd_w[0]);
      end
      test_single(0, 9'h00F, "after_abort_0f");
   endtask

   initial begin
      tests     = 0;
      failed    = 0;
      sys_rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         data_v[i]  = 9'h000;
         valid_v[i] = 1'b0;
      end
      test_reset();
      test_single(0, 9'h096, "lsb_8n1");
      test_single(1, 9'h096, "msb_first");
      test_single(2, 9'h096, "even_parity");
      test_single(3, 9'h096, "odd_parity");
      test_single(4, 9'h096, "even_2stop");
      test_single(5, 9'h016, "width5_odd");
      test_single(3, 9'h0C1, "odd_parity_c1");
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. It serialises one parallel word per valid/ready handshake into a standard asynchronous frame: start bit, data, optional parity, then 1 or 2 stop bits. Data width, bit order, parity mode and stop-bit count are set at elaboration. It sits between the user-side byte source and the uart_txd pin, and supersedes the fixed 8-bit bit-reorder helper.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, must be >= 2)
DATA_WIDTH, 8, data bits per frame, legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
MSB_FIRST, 0, 0 = LSB transmitted first (UART standard), 1 = MSB first (reversed order)

Ports:
sys_clk  input  1  system clock, rising edge
sys_rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  word to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word this cycle
uart_txd  output  1  serial line, idle high, registered
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-cycle pulse after the final stop bit completes

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted: uart_txd=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, counters=0.
- tx_ready goes to 1 on the first sys_clk edge after reset is released.
- States are IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE=0.
- Handshake: a word is accepted when tx_valid && tx_ready are both high at a rising edge.
  - tx_ready=1 only in IDLE; it drops to 0 on the accept edge.
  - On accept, tx_data is latched into the shift register, pre-reversed if MSB_FIRST=1.
  - The parity bit is computed from the latched word: even = ^data, odd = ~^data.
- Bit timing: the state moves to START on the accept edge, so uart_txd=0 from the cycle after accept.
  - Each bit is held for exactly CLKS_PER_BIT cycles, counted by a baud counter running 0..CLKS_PER_BIT-1.
  - The baud counter clears on every state or bit transition.
- DATA state: a bit index counts 0..DATA_WIDTH-1 and the shift register shifts right once per bit. uart_txd = shift_reg[0].
- STOP state: uart_txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length from the first start-bit cycle to the end of the last stop bit is (1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- End of frame: on the last stop-bit cycle the state goes to IDLE.
  - In the first IDLE cycle: tx_done=1 for exactly one cycle, tx_ready=1, tx_busy=0.
- Back-to-back: if tx_valid is high in that first IDLE cycle, the next word is accepted at once. The next start bit follows with no extra idle gap on the line, and the stop bit(s) are never shortened.
- tx_valid and tx_data are ignored while tx_ready=0. A word held across a busy frame is not double-accepted.
- Reset asserted mid-frame: the frame is aborted immediately and uart_txd returns to 1 asynchronously. No tx_done pulse is produced.
- All outputs are registered. uart_txd has no combinational path from the inputs.

Test Plan:
- Use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clk/bit) throughout.
- Defaults (8N1, LSB first): send 8'h96 -> after the start bit (10 cycles low) the line carries 0,1,1,0,1,0,0,1, each 10 cycles, then 10 cycles high. tx_done pulses once, exactly 100 cycles after the start bit began.
- MSB_FIRST=1, 8'h96 -> data bits 1,0,0,1,0,1,1,0. Frame length is unchanged at 100 cycles.
- Parity with 8'h96 (four ones): PARITY_MODE=2 gives parity bit 0, PARITY_MODE=1 gives parity bit 1. Frame length is 110 cycles; with STOP_BITS=2 it is 120 cycles and the line stays high for 20 cycles.
- Back-to-back: tx_valid held high with 8'h55 then 8'hA3 -> two accepts, each followed by its frame. The second start bit begins exactly 100 cycles after the first. Exactly 2 tx_done pulses. tx_ready is high for only 1 cycle between the frames.
- Reset mid-frame: assert sys_rst_n=0 during data bit 3 -> uart_txd=1 without waiting for a clock, no tx_done. tx_ready=1 one cycle after release, and a new 8'h0F frame then transmits correctly.
- DATA_WIDTH=5, value 5'b10110, PARITY_MODE=1 -> bits 0,1,1,0,1 then parity 0 (three ones, so parity 0 makes the total odd). Frame length is 80 cycles.
